// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered reset release across NUM_STAGES downstream domains
// Holds all stage resets, waits for lock, then releases stage 0..N-1 STAGE_GAP cycles apart.
module reset_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sw_req,
   input  logic                  lock_ok,
   output logic [NUM_STAGES-1:0] rst_out,
   output logic                  seq_done,
   output logic                  busy
);

   localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {
      ST_ASSERT    = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_DONE      = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0]   rst_out_q, rst_out_d;
   logic                    seq_done_q, seq_done_d;
   logic                    busy_q, busy_d;
   logic                    restart;

   assign restart = sw_req || !lock_ok;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rst_out_d  = rst_out_q;
      seq_done_d = seq_done_q;

      case (state_q)
         ST_ASSERT: begin
            rst_out_d = '1;
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = ST_WAIT_LOCK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_WAIT_LOCK: begin
            rst_out_d = '1;
            if (lock_ok) begin
               cnt_d = '0;
               if (NUM_STAGES == 1) begin
                  rst_out_d  = '0;
                  seq_done_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  rst_out_d[0] = 1'b0;
                  idx_d        = IDX_W'(1);
                  state_d      = ST_RELEASE;
               end
            end
         end

         ST_RELEASE: begin
            // Restart has priority over a release falling on the same edge.
            if (restart) begin
               state_d    = ST_ASSERT;
               cnt_d      = '0;
               idx_d      = '0;
               rst_out_d  = '1;
               seq_done_d = 1'b0;
            end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               cnt_d = '0;
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (IDX_W'(k) == idx_q) rst_out_d[k] = 1'b0;
               end
               if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                  state_d    = ST_DONE;
                  seq_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            if (restart) begin
               state_d    = ST_ASSERT;
               cnt_d      = '0;
               idx_d      = '0;
               rst_out_d  = '1;
               seq_done_d = 1'b0;
            end
         end

         default: begin
            state_d    = ST_ASSERT;
            cnt_d      = '0;
            idx_d      = '0;
            rst_out_d  = '1;
            seq_done_d = 1'b0;
         end
      endcase

      busy_d = !seq_done_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_ASSERT;
         cnt_q      <= '0;
         idx_q      <= '0;
         rst_out_q  <= '1;
         seq_done_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_out_q  <= rst_out_d;
         seq_done_q <= seq_done_d;
         busy_q     <= busy_d;
      end
   end

   assign rst_out  = rst_out_q;
   assign seq_done = seq_done_q;
   assign busy     = busy_q;

endmodule
